// File: rtl/dlx_mem_pkg.sv
// Shared types and helpers for the DLX instruction/data memory models.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } romem_state_t;

    localparam int IRAM_WORD_SIZE    = 32;
    localparam int IRAM_ADDRESS_SIZE = 32;

    // Byte address to word index; wide enough for any address up to 64 bits.
    function automatic logic [61:0] word_index(input logic [63:0] addr);
        return 62'(addr >> 2);
    endfunction

endpackage

// File: rtl/dlx_mem_delay.sv
// Fixed-latency countdown shared by the DLX memories: load arms it, done flags expiry.
module dlx_mem_delay #(
    parameter int DELAY = 2,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic done
);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    // done is seen on the edge that finds the count at zero, DELAY edges after load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= CNT_W'(DELAY - 1);
            armed <= 1'b1;
        end else if (clear) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = armed && (cnt == '0);

endmodule

// File: rtl/dlx_romem.sv
// Read-only instruction memory on the DLX IRAM port; each new request is answered
// after DATA_DELAY cycles with data_ready.
module dlx_romem
    import dlx_mem_pkg::*;
#(
    parameter string FILE_PATH    = "",
    parameter int    WORD_SIZE    = IRAM_WORD_SIZE,
    parameter int    ADDRESS_SIZE = IRAM_ADDRESS_SIZE,
    parameter int    DEPTH        = 1024,
    parameter int    DATA_DELAY   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic                    enable,
    output logic                    data_ready,
    output logic [WORD_SIZE-1:0]    data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_SIZE-1:0]    mem [DEPTH];
    romem_state_t            state;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic                    accept;
    logic                    delay_done;
    logic [61:0]             idx;
    logic [WORD_SIZE-1:0]    rd_word;

    // Contents start at zero; words not written by a preload stay zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    // A changed address restarts the latency even if a read is pending or done.
    assign accept = enable && ((state == IDLE) || (address != addr_q));

    assign idx = word_index(64'(addr_q));

    always_comb begin
        rd_word = '0;
        if (idx < 62'(DEPTH)) begin
            rd_word = mem[idx[IDX_W-1:0]];
        end
    end

    dlx_mem_delay #(
        .DELAY (DATA_DELAY),
        .CNT_W (4)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .clear (!enable),
        .done  (delay_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_ready <= 1'b0;
            data       <= '0;
        end else if (!enable) begin
            state      <= IDLE;
            data_ready <= 1'b0;
        end else if (accept) begin
            addr_q     <= address;
            state      <= WAIT;
            data_ready <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (delay_done) begin
                        state      <= READY;
                        data_ready <= 1'b1;
                        data       <= rd_word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlx_romem.sv
// Directed scoreboard bench for dlx_romem with DATA_DELAY=2 and DEPTH=1024.
module tb_dlx_romem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic        enable = 1'b0;
    logic        data_ready;
    logic [31:0] data;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    dlx_romem #(
        .FILE_PATH    (""),
        .WORD_SIZE    (32),
        .ADDRESS_SIZE (32),
        .DEPTH        (1024),
        .DATA_DELAY   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .enable     (enable),
        .data_ready (data_ready),
        .data       (data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input int i);
        logic [15:0] lo;
        lo = 16'(i);
        if (i >= 1024) return 32'h0;
        if (i == 1) return 32'h20010005;
        return {lo ^ 16'hC3A5, lo ^ 16'h5A0D};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] a);
        enable  = 1'b1;
        address = a;
        exp_q.push_back(model_word(int'(a >> 2)));
    endtask

    // Edge 0 is the accept edge; returns after data_ready is seen or the budget runs out.
    task automatic wait_ready(input string tag, input int exp_lat);
        int lat;
        bit seen;
        logic [31:0] exp;
        lat  = 99;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (data_ready) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        exp = 32'hDEADBEEF;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check({tag, " data"}, data, exp);
    endtask

    initial begin
        #2;
        for (int i = 0; i < 1024; i++) dut.mem[i] = model_word(i);

        step();
        step();
        check("reset ready", 32'(data_ready), 32'h0);
        check("reset data", data, 32'h0);
        rst = 1'b0;
        step();

        request(32'h4);
        wait_ready("basic", 2);
        step();
        check("hold ready", 32'(data_ready), 32'h1);
        check("hold data", data, 32'h20010005);

        enable = 1'b0;
        step();
        check("drop ready", 32'(data_ready), 32'h0);
        check("drop data", data, 32'h20010005);
        request(32'h4);
        wait_ready("reenable", 2);

        request(32'h0);
        step();
        check("switch accept ready", 32'(data_ready), 32'h0);
        exp_q.delete();
        request(32'h8);
        wait_ready("switch", 2);

        request(32'h0000_0FFC);
        wait_ready("top word", 2);
        request(32'h0000_1000);
        wait_ready("out of range", 2);
        request(32'h0000_0007);
        wait_ready("unaligned", 2);

        request(32'h0000_000C);
        step();
        rst = 1'b1;
        #1;
        check("async reset ready", 32'(data_ready), 32'h0);
        check("async reset data", data, 32'h0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) step();
        check("reset hold ready", 32'(data_ready), 32'h0);
        enable = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post reset ready", 32'(data_ready), 32'h0);
        end
        check("post reset data", data, 32'h0);
        request(32'h0000_000C);
        wait_ready("fresh", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
